// File: rtl/sales_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sales_pkg: shared widths and accumulator type for the sales tracker |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sales_pkg;

    localparam int unsigned C_W     = 32;
    localparam int unsigned C_ACC_W = 64;

    typedef logic [C_ACC_W-1:0] acc_t;

endpackage : sales_pkg
`default_nettype wire

// File: rtl/udiv_comb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | udiv_comb: combinational restoring divider, quotient only          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module udiv_comb #(
    parameter int unsigned ACC_W = 64
) (
    input  logic [ACC_W-1:0] dividend_i,
    input  logic [ACC_W-1:0] divisor_i,
    output logic [ACC_W-1:0] quotient_o
);

    logic [ACC_W-1:0] w_quot;

    // Stage i resolves quotient bit ACC_W-1-i; the partial remainder stays
    // below the divisor, so one extra bit on the shifted value is enough.
    for (genvar i = 0; i < ACC_W; i++) begin : g_stage
        logic [ACC_W-1:0] w_rin;
        logic [ACC_W-1:0] w_rout;
        logic [ACC_W:0]   w_shift;
        logic [ACC_W:0]   w_diff;
        logic             w_ge;

        if (i == 0) begin : g_first
            assign w_rin = '0;
        end else begin : g_next
            assign w_rin = g_stage[i-1].w_rout;
        end

        assign w_shift = {w_rin, dividend_i[ACC_W-1-i]};
        assign w_diff  = w_shift - {1'b0, divisor_i};
        assign w_ge    = (w_shift >= {1'b0, divisor_i});
        assign w_rout  = w_ge ? w_diff[ACC_W-1:0] : w_shift[ACC_W-1:0];
        assign w_quot[ACC_W-1-i] = w_ge;
    end

    assign quotient_o = (divisor_i == '0) ? '0 : w_quot;

endmodule : udiv_comb
`default_nettype wire

// File: rtl/sales.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sales: running floor(revenue / quantity) tracker                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sales
    import sales_pkg::*;
#(
    parameter int unsigned W     = C_W,
    parameter int unsigned ACC_W = C_ACC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] price,
    input  logic [W-1:0] num,
    output logic [W-1:0] avg
);

    logic [ACC_W-1:0] rev_q, rev_d;
    logic [ACC_W-1:0] qty_q, qty_d;
    logic [2*W-1:0]   w_prod;
    logic [ACC_W:0]   w_rev_sum;
    logic [ACC_W:0]   w_qty_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_quot;
    logic             w_unused_quot;

    assign w_prod    = {{W{1'b0}}, price} * {{W{1'b0}}, num};
    assign w_rev_sum = {1'b0, rev_q} + {{(ACC_W+1-2*W){1'b0}}, w_prod};
    assign w_qty_sum = {1'b0, qty_q} + {{(ACC_W+1-W){1'b0}}, num};

    // A carry out of either sum drops the whole transaction, keeping the pair consistent.
    assign w_ovf = w_rev_sum[ACC_W] | w_qty_sum[ACC_W];

    always_comb begin
        rev_d = rev_q;
        qty_d = qty_q;
        if (!w_ovf) begin
            rev_d = w_rev_sum[ACC_W-1:0];
            qty_d = w_qty_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rev_q <= '0;
            qty_q <= '0;
        end else begin
            rev_q <= rev_d;
            qty_q <= qty_d;
        end
    end

    udiv_comb #(
        .ACC_W(ACC_W)
    ) u_div (
        .dividend_i(rev_q),
        .divisor_i (qty_q),
        .quotient_o(w_quot)
    );

    // The quotient never exceeds the largest price, so the upper bits are always zero.
    assign avg           = w_quot[W-1:0];
    assign w_unused_quot = &{1'b0, w_quot[ACC_W-1:W]};

endmodule : sales
`default_nettype wire

// File: tb/tb_sales.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sales: vector table + scoreboard bench for the sales tracker    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sales;
    import sales_pkg::*;

    localparam int unsigned W     = C_W;
    localparam int unsigned ACC_W = C_ACC_W;
    localparam logic [W-1:0] MAXV = '1;

    logic         clk;
    logic         rst;
    logic [W-1:0] price;
    logic [W-1:0] num;
    logic [W-1:0] avg;

    sales #(
        .W    (W),
        .ACC_W(ACC_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .price(price),
        .num  (num),
        .avg  (avg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [W-1:0] price;
        logic [W-1:0] num;
        logic [W-1:0] exp_avg;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference state for the hand-written sequences
    logic [ACC_W:0] m_rev;
    logic [ACC_W:0] m_qty;

    task automatic compare(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: avg=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input string tag, input logic r, input logic [W-1:0] p,
                         input logic [W-1:0] n, input logic [W-1:0] e);
        logic [W-1:0] exp_v;
        @(negedge clk);
        rst   = r;
        price = p;
        num   = n;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, avg=%h expected none", tag, avg);
        end else begin
            exp_v = exp_q.pop_front();
            compare(tag, avg, exp_v);
        end
    endtask

    task automatic model_step(input string tag, input logic r, input logic [W-1:0] p,
                              input logic [W-1:0] n);
        logic [ACC_W:0] prod;
        logic [ACC_W:0] nrev;
        logic [ACC_W:0] nqty;
        logic [ACC_W:0] quo;
        logic [W-1:0]   e;
        prod = (ACC_W+1)'(p) * (ACC_W+1)'(n);
        if (r) begin
            m_rev = '0;
            m_qty = '0;
        end else begin
            nrev = m_rev + prod;
            nqty = m_qty + (ACC_W+1)'(n);
            if (!nrev[ACC_W] && !nqty[ACC_W]) begin
                m_rev = nrev;
                m_qty = nqty;
            end
        end
        quo = (m_qty == '0) ? '0 : (m_rev / m_qty);
        e   = quo[W-1:0];
        drive(tag, r, p, n, e);
    endtask

    vec_t vecs[16];

    initial begin
        rst   = 1'b1;
        price = '0;
        num   = '0;

        vecs[0]  = '{1'b1, 32'd0,  32'd0, 32'd0};   // reset state
        vecs[1]  = '{1'b0, 32'd1,  32'd2, 32'd1};   // 2/2
        vecs[2]  = '{1'b0, 32'd2,  32'd1, 32'd1};   // 4/3
        vecs[3]  = '{1'b0, 32'd3,  32'd3, 32'd2};   // 13/6
        vecs[4]  = '{1'b1, 32'd0,  32'd0, 32'd0};
        vecs[5]  = '{1'b0, 32'd99, 32'd0, 32'd0};   // empty, num=0
        vecs[6]  = '{1'b0, 32'd10, 32'd5, 32'd10};
        vecs[7]  = '{1'b1, 32'd50, 32'd5, 32'd0};   // reset wins over transaction
        vecs[8]  = '{1'b0, 32'd7,  32'd1, 32'd7};
        vecs[9]  = '{1'b1, 32'd0,  32'd0, 32'd0};
        vecs[10] = '{1'b0, 32'd5,  32'd1, 32'd5};
        vecs[11] = '{1'b0, 32'd6,  32'd1, 32'd5};   // 11/2
        vecs[12] = '{1'b0, 32'd1,  32'd1, 32'd4};   // 12/3
        vecs[13] = '{1'b1, 32'd0,  32'd0, 32'd0};
        vecs[14] = '{1'b0, MAXV,   MAXV,  MAXV};
        vecs[15] = '{1'b0, 32'd0,  MAXV,  32'h7FFF_FFFF};

        for (int i = 0; i < 16; i++) begin
            drive($sformatf("vec%0d", i), vecs[i].rst, vecs[i].price, vecs[i].num, vecs[i].exp_avg);
        end

        // avg must not follow the live inputs between edges
        @(negedge clk);
        price = 32'd1234;
        num   = 32'd1;
        #2;
        compare("live_inputs", avg, 32'h7FFF_FFFF);

        // Saturation: the second max*max product would carry out of the accumulator
        model_step("ovf_rst", 1'b1, '0, '0);
        for (int i = 0; i < 5; i++) begin
            model_step($sformatf("ovf%0d", i), 1'b0, MAXV, MAXV);
        end
        model_step("ovf_hold0", 1'b0, MAXV, 32'd2);
        model_step("ovf_hold1", 1'b0, MAXV, MAXV);
        model_step("ovf_clr", 1'b1, MAXV, MAXV);
        model_step("ovf_after", 1'b0, 32'd7, 32'd1);
        model_step("mix0", 1'b0, 32'd1000, 32'd3);
        model_step("mix1", 1'b0, 32'd17, 32'd9);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t expected finish before 200000", $time);
        $fatal(1);
    end

endmodule : tb_sales
`default_nettype wire
